// File: rtl/led_sequencer_pkg.sv
// led_sequencer shared types and constants.
// Mode/state encodings and pattern seeds for the LED bank.
package led_seq_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLINK = 2'd1,
    S_SHIFT = 2'd2,
    S_COUNT = 2'd3
  } state_e;

  localparam logic [LED_W-1:0] PAT_OFF_INIT   = 8'h00;
  localparam logic [LED_W-1:0] PAT_BLINK_INIT = 8'hFF;
  localparam logic [LED_W-1:0] PAT_SHIFT_INIT = 8'h01;
  localparam logic [LED_W-1:0] PAT_COUNT_INIT = 8'h00;

  function automatic state_e mode_to_state(
    input mode_e m
  );
    state_e s;
    unique case (m)
      MODE_OFF:   s = S_OFF;
      MODE_BLINK: s = S_BLINK;
      MODE_SHIFT: s = S_SHIFT;
      MODE_COUNT: s = S_COUNT;
      default:    s = S_OFF;
    endcase
    return s;
  endfunction

  function automatic logic [LED_W-1:0] init_pat(
    input state_e s
  );
    logic [LED_W-1:0] p;
    unique case (s)
      S_OFF:   p = PAT_OFF_INIT;
      S_BLINK: p = PAT_BLINK_INIT;
      S_SHIFT: p = PAT_SHIFT_INIT;
      S_COUNT: p = PAT_COUNT_INIT;
      default: p = PAT_OFF_INIT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control/status bundle between the LED sequencer and its host.
// dim exists only when LED_PWM_DIM_EN is defined.
interface led_seq_if;
  import led_seq_pkg::*;

  logic [1:0]       mode_sel;
  logic             mode_load;
  logic [3:0]       speed;
  logic             pause;
  logic             ovr_req;
  logic [LED_W-1:0] ovr_data;
  logic             ovr_gnt;
  logic             step;
  logic [LED_W-1:0] LEDG;
`ifdef LED_PWM_DIM_EN
  logic [2:0]       dim;
`endif

  modport master (
    output mode_sel, mode_load, speed,
    output pause, ovr_req, ovr_data,
`ifdef LED_PWM_DIM_EN
    output dim,
`endif
    input  ovr_gnt, step, LEDG
  );

  modport slave (
    input  mode_sel, mode_load, speed,
    input  pause, ovr_req, ovr_data,
`ifdef LED_PWM_DIM_EN
    input  dim,
`endif
    output ovr_gnt, step, LEDG
  );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler plus speed-scaled step counter for the sequencer.
// speed is latched only at period start so a change never shortens a step.
module led_tick_gen #(
  parameter int TICK_DIV = 2500000,
  parameter int CNT_W    = 22
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       clear,
  input  logic       pause,
  input  logic [3:0] speed,
  output logic       tick
);

  localparam logic [CNT_W-1:0] BASE_MAX =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] base_q;
  logic [3:0]       step_q;
  logic [3:0]       speed_q;
  logic             base_wrap;
  logic             step_wrap;

  assign base_wrap = (base_q == BASE_MAX);
  assign step_wrap = (step_q == speed_q);
  assign tick      = !pause && base_wrap && step_wrap;

  // Base counter wraps every TICK_DIV; step counter advances per wrap.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      base_q  <= '0;
      step_q  <= '0;
      speed_q <= '0;
    end else if (clear) begin
      base_q  <= '0;
      step_q  <= '0;
      speed_q <= speed;
    end else if (!pause) begin
      if (base_wrap) begin
        base_q <= '0;
        if (step_wrap) begin
          step_q  <= '0;
          speed_q <= speed;
        end else begin
          step_q <= step_q + 4'd1;
        end
      end else begin
        base_q <= base_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// 8-bit LED pattern sequencer with fixed-priority external override.
// Optional LED_PWM_DIM_EN adds a 3-bit PWM brightness gate on LEDG.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 2500000,
  parameter int CNT_W    = 22
) (
  input logic     CLOCK_50,
  input logic     RESET,
  led_seq_if.slave bus
);

  logic             tick;
  state_e           state_q;
  state_e           state_d;
  logic [LED_W-1:0] pat_q;
  logic [LED_W-1:0] pat_d;
  logic             dir_q;
  logic             dir_d;
  logic [LED_W-1:0] led_d;
  logic [LED_W-1:0] led_q;
  logic             gnt_q;
  logic             step_q;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clear    (bus.mode_load),
    .pause    (bus.pause),
    .speed    (bus.speed),
    .tick     (tick)
  );

  // Next state and pattern; a load beats a coincident tick.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    if (bus.mode_load) begin
      state_d = mode_to_state(mode_e'(bus.mode_sel));
      pat_d   = init_pat(state_d);
      dir_d   = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        S_OFF:   pat_d = PAT_OFF_INIT;
        S_BLINK: pat_d = ~pat_q;
        S_SHIFT: begin
          if (dir_q) begin
            pat_d = pat_q >> 1;
            if (pat_d[0]) dir_d = 1'b0;
          end else begin
            pat_d = pat_q << 1;
            if (pat_d[LED_W-1]) dir_d = 1'b1;
          end
        end
        S_COUNT: pat_d = pat_q + 8'd1;
        default: pat_d = pat_q;
      endcase
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [2:0] pwm_q;
  logic       pwm_on;

  assign pwm_on = ({1'b0, pwm_q} < ({1'b0, bus.dim} + 4'd1));

  // Free-running PWM phase for the brightness gate.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) pwm_q <= '0;
    else       pwm_q <= pwm_q + 3'd1;
  end

  // Override wins, then the brightness gate applies to either source.
  always_comb begin
    led_d = bus.ovr_req ? bus.ovr_data : pat_d;
    led_d = led_d & {LED_W{pwm_on}};
  end
`else
  // Override wins over the sequencer pattern.
  always_comb begin
    led_d = bus.ovr_req ? bus.ovr_data : pat_d;
  end
`endif

  // State, pattern, grant and LED output registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_OFF;
      pat_q   <= PAT_OFF_INIT;
      dir_q   <= 1'b0;
      led_q   <= '0;
      gnt_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      gnt_q   <= bus.ovr_req;
      step_q  <= tick && !bus.mode_load;
    end
  end

  assign bus.LEDG    = led_q;
  assign bus.ovr_gnt = gnt_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4.
// Outputs are sampled on the falling clock edge.
module tb_led_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  led_seq_if bus();

  led_sequencer #(
    .TICK_DIV (4),
    .CNT_W    (2)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_step(
    input  int lim,
    output int n
  );
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step !== 1'b1 && n < lim);
    if (bus.step !== 1'b1)
      chk("step_timeout", int'(bus.step), 1);
  endtask

  task automatic load(input logic [1:0] m);
    bus.mode_sel  = m;
    bus.mode_load = 1'b1;
    @(negedge clk);
    bus.mode_load = 1'b0;
  endtask

  logic [7:0] shift_exp [16] = '{
    8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h40,
    8'h20, 8'h10, 8'h08, 8'h04,
    8'h02, 8'h01, 8'h02, 8'h04
  };

  initial begin
    int n;
    bit stuck;
    bus.mode_sel  = 2'd0;
    bus.mode_load = 1'b0;
    bus.speed     = 4'd0;
    bus.pause     = 1'b0;
    bus.ovr_req   = 1'b0;
    bus.ovr_data  = 8'h00;
`ifdef LED_PWM_DIM_EN
    bus.dim       = 3'd7;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_led",  int'(bus.LEDG), 8'h00);
    chk("rst_gnt",  int'(bus.ovr_gnt), 0);
    chk("rst_step", int'(bus.step), 0);

    // walking one bounce
    load(2'd2);
    chk("shift_load", int'(bus.LEDG), 8'h01);
    for (int i = 0; i < 16; i++) begin
      wait_step(20, n);
      chk("shift_gap", n, 4);
      chk("shift_led", int'(bus.LEDG), int'(shift_exp[i]));
    end

    // count with speed=2, including wrap
    bus.speed = 4'd2;
    load(2'd3);
    chk("cnt_load", int'(bus.LEDG), 8'h00);
    wait_step(40, n);
    chk("cnt_gap1", n, 12);
    chk("cnt_1", int'(bus.LEDG), 8'h01);
    wait_step(40, n);
    chk("cnt_gap2", n, 12);
    chk("cnt_2", int'(bus.LEDG), 8'h02);
    for (int i = 3; i < 256; i++) wait_step(40, n);
    chk("cnt_ff", int'(bus.LEDG), 8'hFF);
    wait_step(40, n);
    chk("cnt_gapw", n, 12);
    chk("cnt_wrap", int'(bus.LEDG), 8'h00);

    // blink with pause
    bus.speed = 4'd0;
    load(2'd1);
    chk("blink_load", int'(bus.LEDG), 8'hFF);
    wait_step(20, n);
    chk("blink_gap", n, 4);
    chk("blink_0", int'(bus.LEDG), 8'h00);
    bus.pause = 1'b1;
    stuck = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.step !== 1'b0 || bus.LEDG !== 8'h00)
        stuck = 1'b0;
    end
    chk("pause_frozen", int'(stuck), 1);
    bus.pause = 1'b0;
    wait_step(20, n);
    chk("pause_rel_gap", n, 4);
    chk("pause_rel_led", int'(bus.LEDG), 8'hFF);

    // override during count
    load(2'd3);
    for (int i = 0; i < 5; i++) wait_step(20, n);
    chk("ovr_pre", int'(bus.LEDG), 8'h05);
    bus.ovr_data = 8'hA5;
    bus.ovr_req  = 1'b1;
    @(negedge clk);
    chk("ovr_gnt", int'(bus.ovr_gnt), 1);
    chk("ovr_led", int'(bus.LEDG), 8'hA5);
    bus.ovr_data = 8'h3C;
    @(negedge clk);
    chk("ovr_track", int'(bus.LEDG), 8'h3C);
    repeat (7) @(negedge clk);
    bus.ovr_req = 1'b0;
    @(negedge clk);
    chk("ovr_rel_gnt", int'(bus.ovr_gnt), 0);
    chk("ovr_rel_led", int'(bus.LEDG), 8'h07);

    // load on the same edge as a tick
    wait_step(20, n);
    repeat (3) @(negedge clk);
    load(2'd2);
    chk("ld_tick_led", int'(bus.LEDG), 8'h01);
    chk("ld_tick_step", int'(bus.step), 0);
    wait_step(20, n);
    chk("ld_tick_gap", n, 4);
    chk("ld_tick_nxt", int'(bus.LEDG), 8'h02);

    // asynchronous reset with override held
    bus.ovr_data = 8'h5A;
    bus.ovr_req  = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_gnt", int'(bus.ovr_gnt), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_led", int'(bus.LEDG), 8'h00);
    chk("arst_gnt", int'(bus.ovr_gnt), 0);
    @(negedge clk);
    bus.ovr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_step(20, n);
      chk("off_led", int'(bus.LEDG), 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
